// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: per-register pipe control encoding and register index type.
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      PIPE_ENABLE = 2'b00,
      PIPE_STALL  = 2'b01,
      PIPE_NOP    = 2'b10
   } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Central stall/flush controller for the five-stage pipeline, with stall/flush perf counters.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_RUN     | normal operation, hazard priority rules resolve each cycle
//   ST_DRAIN   | halt accepted; one cycle of bubbles through every register
//   ST_HALTED  | pipeline frozen, halted asserted until reset
module pipeline_hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_mem,
   input  logic             dWEN_mem,
   input  logic             dREN_ex,
   input  regbits_t         rt_ex,
   input  regbits_t         rs_dec,
   input  regbits_t         rt_dec,
   input  logic             uses_rt_dec,
   input  logic             branch_taken_ex,
   input  logic             halt_mem,
   output logic             pc_en,
   output pipe_state_t      fd_state,
   output pipe_state_t      de_state,
   output pipe_state_t      em_state,
   output pipe_state_t      mw_state,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } hzd_state_t;

   hzd_state_t r_state;
   hzd_state_t w_next_state;

   logic w_mem_busy;
   logic w_load_use;
   logic w_stall_inc;
   logic w_flush_inc;

   assign w_mem_busy = (dREN_mem | dWEN_mem) & ~dhit;

   // $zero is hardwired, so a load targeting it can never create a dependency.
   assign w_load_use = dREN_ex & (rt_ex != '0)
                     & ((rt_ex == rs_dec) | (uses_rt_dec & (rt_ex == rt_dec)));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      pc_en        = 1'b1;
      fd_state     = PIPE_ENABLE;
      de_state     = PIPE_ENABLE;
      em_state     = PIPE_ENABLE;
      mw_state     = PIPE_ENABLE;
      halted       = 1'b0;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_mem_busy) begin
               pc_en       = 1'b0;
               fd_state    = PIPE_STALL;
               de_state    = PIPE_STALL;
               em_state    = PIPE_STALL;
               mw_state    = PIPE_NOP;
               w_stall_inc = 1'b1;
            end else if (halt_mem) begin
               pc_en        = 1'b0;
               fd_state     = PIPE_NOP;
               de_state     = PIPE_NOP;
               em_state     = PIPE_NOP;
               w_stall_inc  = 1'b1;
               w_next_state = ST_DRAIN;
            end else if (branch_taken_ex) begin
               // Flushing decode also kills any load-use dependent there.
               fd_state    = PIPE_NOP;
               de_state    = PIPE_NOP;
               w_flush_inc = 1'b1;
            end else if (w_load_use) begin
               pc_en       = 1'b0;
               fd_state    = PIPE_STALL;
               de_state    = PIPE_NOP;
               w_stall_inc = 1'b1;
            end else if (!ihit) begin
               pc_en       = 1'b0;
               fd_state    = PIPE_NOP;
               w_stall_inc = 1'b1;
            end
         end
         ST_DRAIN: begin
            pc_en        = 1'b0;
            fd_state     = PIPE_NOP;
            de_state     = PIPE_NOP;
            em_state     = PIPE_NOP;
            mw_state     = PIPE_NOP;
            w_next_state = ST_HALTED;
         end
         ST_HALTED: begin
            pc_en    = 1'b0;
            fd_state = PIPE_STALL;
            de_state = PIPE_STALL;
            em_state = PIPE_STALL;
            mw_state = PIPE_STALL;
            halted   = 1'b1;
         end
         default: begin
            w_next_state = ST_RUN;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .i_inc (w_stall_inc),
      .o_cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .i_inc (w_flush_inc),
      .o_cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed scenarios plus random traffic against a reference model.
module tb_pipeline_hazard_unit;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic ihit = 1'b1, dhit = 1'b0, dREN_mem = 1'b0, dWEN_mem = 1'b0, dREN_ex = 1'b0;
   regbits_t rt_ex = '0, rs_dec = '0, rt_dec = '0;
   logic uses_rt_dec = 1'b0, branch_taken_ex = 1'b0, halt_mem = 1'b0;

   logic        pc_en, halted;
   pipe_state_t fd_state, de_state, em_state, mw_state;
   logic [15:0] stall_cnt, flush_cnt;

   logic        pc_en_s, halted_s;
   pipe_state_t fd_state_s, de_state_s, em_state_s, mw_state_s;
   logic [3:0]  stall_cnt_s, flush_cnt_s;

   always #5 CLK = ~CLK;

   pipeline_hazard_unit #(.CNT_W(16)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem),
      .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex), .rt_ex(rt_ex), .rs_dec(rs_dec),
      .rt_dec(rt_dec), .uses_rt_dec(uses_rt_dec), .branch_taken_ex(branch_taken_ex),
      .halt_mem(halt_mem), .pc_en(pc_en), .fd_state(fd_state), .de_state(de_state),
      .em_state(em_state), .mw_state(mw_state), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_unit #(.CNT_W(4)) dut_s (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem),
      .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex), .rt_ex(rt_ex), .rs_dec(rs_dec),
      .rt_dec(rt_dec), .uses_rt_dec(uses_rt_dec), .branch_taken_ex(branch_taken_ex),
      .halt_mem(halt_mem), .pc_en(pc_en_s), .fd_state(fd_state_s), .de_state(de_state_s),
      .em_state(em_state_s), .mw_state(mw_state_s), .halted(halted_s),
      .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: mode 0 = running, 1 = draining, 2 = halted; counts kept unbounded.
   int          m_mode = 0;
   int          m_stall = 0;
   int          m_flush = 0;
   logic        e_pc, e_halted;
   pipe_state_t e_fd, e_de, e_em, e_mw;
   int          e_sinc, e_finc, e_next;

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic set_exp(input logic pc, input pipe_state_t fd, input pipe_state_t de,
                          input pipe_state_t em, input pipe_state_t mw);
      e_pc = pc; e_fd = fd; e_de = de; e_em = em; e_mw = mw;
   endtask

   task automatic model_eval();
      bit busy, luse;
      busy = (dREN_mem || dWEN_mem) && !dhit;
      luse = dREN_ex && (rt_ex != 0) &&
             ((rt_ex == rs_dec) || (uses_rt_dec && (rt_ex == rt_dec)));
      e_halted = (m_mode == 2);
      e_sinc = 0; e_finc = 0; e_next = m_mode;
      if (m_mode == 1) begin
         set_exp(1'b0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP);
         e_next = 2;
      end else if (m_mode == 2) begin
         set_exp(1'b0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL);
      end else if (busy) begin
         set_exp(1'b0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP);
      end else if (halt_mem) begin
         set_exp(1'b0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE);
         e_next = 1;
      end else if (branch_taken_ex) begin
         set_exp(1'b1, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE);
         e_finc = 1;
      end else if (luse) begin
         set_exp(1'b0, PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE);
      end else if (!ihit) begin
         set_exp(1'b0, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE);
      end else begin
         set_exp(1'b1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE);
      end
      if (m_mode == 0 && !e_pc) e_sinc = 1;
   endtask

   task automatic compare_all();
      model_eval();
      chk("pc_en",    32'(pc_en),    32'(e_pc));
      chk("fd_state", 32'(fd_state), 32'(e_fd));
      chk("de_state", 32'(de_state), 32'(e_de));
      chk("em_state", 32'(em_state), 32'(e_em));
      chk("mw_state", 32'(mw_state), 32'(e_mw));
      chk("halted",   32'(halted),   32'(e_halted));
      chk("stall_cnt",   32'(stall_cnt),   32'(sat(m_stall, 65535)));
      chk("flush_cnt",   32'(flush_cnt),   32'(sat(m_flush, 65535)));
      chk("stall_cnt4",  32'(stall_cnt_s), 32'(sat(m_stall, 15)));
      chk("flush_cnt4",  32'(flush_cnt_s), 32'(sat(m_flush, 15)));
      chk("pc_en4",      32'(pc_en_s),     32'(e_pc));
   endtask

   task automatic cycle();
      @(negedge CLK);
      compare_all();
      @(posedge CLK);
      m_stall += e_sinc;
      m_flush += e_finc;
      m_mode   = e_next;
      #1;
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0; dREN_ex = 1'b0;
      rt_ex = '0; rs_dec = '0; rt_dec = '0; uses_rt_dec = 1'b0;
      branch_taken_ex = 1'b0; halt_mem = 1'b0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      m_mode = 0; m_stall = 0; m_flush = 0;
      #2;
      compare_all();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      idle();
      do_reset();
      cycle();

      // Load-use on rs, then released; then the same with $zero as target.
      dREN_ex = 1'b1; rt_ex = 5'd5; rs_dec = 5'd5;
      cycle();
      dREN_ex = 1'b0;
      cycle();
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      dREN_ex = 1'b1; rt_ex = 5'd0; rs_dec = 5'd0;
      cycle();
      chk("lu_r0_stall_cnt", 32'(stall_cnt), 32'd1);
      idle();

      // Data-memory wait for three cycles.
      do_reset();
      dREN_mem = 1'b1; dhit = 1'b0;
      repeat (3) cycle();
      dhit = 1'b1;
      cycle();
      chk("mem_stall_cnt", 32'(stall_cnt), 32'd3);
      idle();

      // Branch together with a load-use match.
      do_reset();
      branch_taken_ex = 1'b1; dREN_ex = 1'b1; rt_ex = 5'd7; rt_dec = 5'd7; uses_rt_dec = 1'b1;
      cycle();
      chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("br_stall_cnt", 32'(stall_cnt), 32'd0);
      idle();

      // Halt behind a pending store, drain, halted, then reset out.
      do_reset();
      halt_mem = 1'b1; dWEN_mem = 1'b1; dhit = 1'b0;
      repeat (2) cycle();
      dhit = 1'b1;
      cycle();
      idle();
      cycle();
      cycle();
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_fd", 32'(fd_state), 32'(PIPE_STALL));
      do_reset();
      chk("halt_cleared", 32'(halted), 32'd0);

      // Reset asserted while draining.
      halt_mem = 1'b1;
      cycle();
      idle();
      do_reset();
      chk("drain_reset_pc", 32'(pc_en), 32'd1);

      // Instruction-miss run long enough to saturate the narrow counter.
      do_reset();
      ihit = 1'b0;
      repeat (20) cycle();
      chk("sat4_stall", 32'(stall_cnt_s), 32'd15);
      chk("sat16_stall", 32'(stall_cnt), 32'd20);
      idle();

      // Random traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         ihit            = ($urandom_range(0, 3) != 0);
         dhit            = $urandom_range(0, 1) != 0;
         dREN_mem        = ($urandom_range(0, 3) == 0);
         dWEN_mem        = ($urandom_range(0, 3) == 0);
         dREN_ex         = $urandom_range(0, 1) != 0;
         rt_ex           = 5'($urandom_range(0, 3));
         rs_dec          = 5'($urandom_range(0, 3));
         rt_dec          = 5'($urandom_range(0, 3));
         uses_rt_dec     = $urandom_range(0, 1) != 0;
         branch_taken_ex = ($urandom_range(0, 5) == 0);
         halt_mem        = ($urandom_range(0, 39) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
